// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter
// Description : Shares one SRAM-like downstream port between the instruction
//               and data SRAM-like masters. Priority grant with
//               anti-starvation, grant locking until accepted, and an
//               in-order tag FIFO that routes data_ok/rdata to the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction master
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    // data master
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    // downstream port
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    output logic        err_unexp_ok
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);
    localparam logic [c_STV_W-1:0] c_STARVE = c_STV_W'(STARVE_LIMIT);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOCK_I = 2'd1;
    localparam logic [1:0] c_ST_LOCK_D = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [DEPTH-1:0]   r_tag;       // 1 = entry belongs to the data master
    logic [c_STV_W-1:0] r_starve_cnt;
    logic               r_err;

    logic w_sel_i;
    logic w_sel_d;
    logic w_starved;
    logic w_full;
    logic w_acc;
    logic w_pop;
    logic w_head_d;

    assign w_starved = (r_starve_cnt >= c_STARVE);
    assign w_full    = (r_count == c_DEPTH);

    // Grant selection: a lock state pins the choice until the address is accepted
    always_comb begin
        w_sel_i = 1'b0;
        w_sel_d = 1'b0;
        case (r_state)
            c_ST_LOCK_I: w_sel_i = 1'b1;
            c_ST_LOCK_D: w_sel_d = 1'b1;
            default: begin
                if (data_req && !(inst_req && w_starved)) begin
                    w_sel_d = 1'b1;
                end else if (inst_req) begin
                    w_sel_i = 1'b1;
                end
            end
        endcase
    end

    // Downstream request and payload; all handshakes forced low while in reset
    assign m_req   = resetn & ((w_sel_i & inst_req) | (w_sel_d & data_req)) & ~w_full;
    assign m_wr    = w_sel_d ? data_wr    : inst_wr;
    assign m_size  = w_sel_d ? data_size  : inst_size;
    assign m_addr  = w_sel_d ? data_addr  : inst_addr;
    assign m_wdata = w_sel_d ? data_wdata : inst_wdata;

    assign w_acc        = m_req & m_addr_ok;
    assign inst_addr_ok = w_acc & w_sel_i;
    assign data_addr_ok = w_acc & w_sel_d;

    // Responses come back in acceptance order, so the FIFO head names the owner
    assign w_head_d     = r_tag[r_rptr];
    assign w_pop        = resetn & m_data_ok & (r_count != '0);
    assign inst_data_ok = w_pop & ~w_head_d;
    assign data_data_ok = w_pop & w_head_d;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign err_unexp_ok = r_err;

    // Grant FSM: lock on an unaccepted request, return to IDLE on acceptance
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
        end else if (m_req) begin
            if (m_addr_ok) begin
                r_state <= c_ST_IDLE;
            end else begin
                r_state <= w_sel_d ? c_ST_LOCK_D : c_ST_LOCK_I;
            end
        end
    end

    // Tag FIFO: push on acceptance, pop on response, both may happen together
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_tag   <= '0;
        end else begin
            if (w_acc) begin
                r_tag[r_wptr] <= w_sel_d;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_acc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Anti-starvation: count data wins while inst waits, clear once inst is served or idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (!inst_req || inst_addr_ok) begin
            r_starve_cnt <= '0;
        end else if (data_addr_ok && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Sticky flag for a response with nothing outstanding
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (m_data_ok && (r_count == '0)) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_arbiter
// Description : Self-checking bench for sram_like_arbiter. Per-cycle vectors
//               give the expected grant; accepted grants feed a scoreboard
//               queue that predicts which master each response belongs to.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

    localparam logic [31:0] c_IADDR  = 32'h1000_0040;
    localparam logic [31:0] c_IWDATA = 32'h1111_1111;
    localparam logic [31:0] c_DADDR  = 32'h2000_0080;
    localparam logic [31:0] c_DWDATA = 32'h2222_2222;

    // sel: 0 = no m_req expected, 1 = inst payload, 2 = data payload
    typedef struct packed {
        logic        ir;
        logic        dr;
        logic        mao;
        logic        mdo;
        logic [31:0] rd;
        logic [1:0]  sel;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, inst_wr = 1'b0, data_req = 1'b0, data_wr = 1'b1;
    logic [1:0]  inst_size = 2'd2, data_size = 2'd1;
    logic [31:0] inst_addr = c_IADDR, inst_wdata = c_IWDATA;
    logic [31:0] data_addr = c_DADDR, data_wdata = c_DWDATA;
    logic [31:0] inst_rdata, data_rdata, m_addr, m_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        m_req, m_wr, err_unexp_ok;
    logic [1:0]  m_size;
    logic [31:0] m_rdata = '0;
    logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  sb_q[$];
    vec_t        vq[$];

    sram_like_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .err_unexp_ok(err_unexp_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic dr, input logic mao,
                                input logic mdo, input logic [31:0] rd, input logic [1:0] sel);
        vec_t v;
        v.ir = ir; v.dr = dr; v.mao = mao; v.mdo = mdo; v.rd = rd; v.sel = sel;
        return v;
    endfunction

    // One clock cycle: drive, sample at the falling edge, update scoreboard
    task automatic cyc(input vec_t v);
        logic [1:0] m;
        logic       exp_i, exp_d;
        inst_req  = v.ir;
        data_req  = v.dr;
        m_addr_ok = v.mao;
        m_data_ok = v.mdo;
        m_rdata   = v.rd;
        @(negedge clk);
        chk("m_req", {67'd0, m_req}, {67'd0, v.sel != 2'd0});
        chk("inst_addr_ok", {67'd0, inst_addr_ok}, {67'd0, (v.sel == 2'd1) && v.mao});
        chk("data_addr_ok", {67'd0, data_addr_ok}, {67'd0, (v.sel == 2'd2) && v.mao});
        if (v.sel == 2'd1)
            chk("payload_inst", {m_wr, m_size, m_addr, m_wdata}, {1'b0, 2'd2, c_IADDR, c_IWDATA});
        if (v.sel == 2'd2)
            chk("payload_data", {m_wr, m_size, m_addr, m_wdata}, {1'b1, 2'd1, c_DADDR, c_DWDATA});
        exp_i = 1'b0;
        exp_d = 1'b0;
        if (v.mdo && sb_q.size() > 0) begin
            m     = sb_q.pop_front();
            exp_i = (m == 2'd1);
            exp_d = (m == 2'd2);
            chk("rdata", {4'd0, inst_rdata, data_rdata}, {4'd0, v.rd, v.rd});
        end
        chk("inst_data_ok", {67'd0, inst_data_ok}, {67'd0, exp_i});
        chk("data_data_ok", {67'd0, data_data_ok}, {67'd0, exp_d});
        if (v.sel != 2'd0 && v.mao) sb_q.push_back(v.sel);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs();
        foreach (vq[i]) cyc(vq[i]);
        vq.delete();
    endtask

    initial begin
        // reset with requests pending: every handshake must stay low
        inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {62'd0, m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexp_ok}, 68'd0);
        inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // inst only, response two cycles after acceptance
        vq.push_back(mk(1, 0, 1, 0, 32'h0, 2'd1));
        vq.push_back(mk(0, 0, 0, 0, 32'h0, 2'd0));
        vq.push_back(mk(0, 0, 0, 1, 32'h1234_5678, 2'd0));
        // data held unaccepted three cycles, inst arrives meanwhile
        vq.push_back(mk(0, 1, 0, 0, 32'h0, 2'd2));
        vq.push_back(mk(1, 1, 0, 0, 32'h0, 2'd2));
        vq.push_back(mk(1, 1, 0, 0, 32'h0, 2'd2));
        vq.push_back(mk(1, 1, 1, 0, 32'h0, 2'd2));
        vq.push_back(mk(1, 0, 1, 0, 32'h0, 2'd1));
        vq.push_back(mk(0, 0, 0, 1, 32'h5555_0001, 2'd0));
        vq.push_back(mk(0, 0, 0, 1, 32'h5555_0002, 2'd0));
        run_vecs();

        // anti-starvation: inst wins after eight straight data grants
        for (int k = 0; k < 10; k++)
            vq.push_back(mk(1, 1, 1, k > 0, 32'hA000_0000 + k, (k == 8) ? 2'd1 : 2'd2));
        vq.push_back(mk(0, 0, 0, 1, 32'hA000_000A, 2'd0));
        run_vecs();

        // tag FIFO full, pop while full, pointer wrap over eight transactions
        for (int k = 0; k < 4; k++) vq.push_back(mk(0, 1, 1, 0, 32'h0, 2'd2));
        vq.push_back(mk(0, 1, 1, 0, 32'h0, 2'd0));
        vq.push_back(mk(0, 1, 1, 1, 32'hB000_0001, 2'd0));
        vq.push_back(mk(0, 1, 1, 0, 32'h0, 2'd2));
        vq.push_back(mk(1, 0, 1, 1, 32'hB000_0002, 2'd0));
        vq.push_back(mk(1, 0, 1, 0, 32'h0, 2'd1));
        vq.push_back(mk(1, 0, 1, 1, 32'hB000_0003, 2'd0));
        vq.push_back(mk(1, 0, 1, 1, 32'hB000_0004, 2'd1));
        vq.push_back(mk(0, 1, 1, 1, 32'hB000_0005, 2'd2));
        for (int k = 0; k < 3; k++) vq.push_back(mk(0, 0, 0, 1, 32'hB000_0010 + k, 2'd0));
        run_vecs();
        chk("sb_drained", {36'd0, 32'(sb_q.size())}, 68'd0);
        chk("err_clear", {67'd0, err_unexp_ok}, 68'd0);

        // unexpected response with nothing outstanding
        cyc(mk(0, 0, 0, 1, 32'hDEAD_0000, 2'd0));
        chk("err_set", {67'd0, err_unexp_ok}, 68'd1);
        cyc(mk(0, 0, 0, 0, 32'h0, 2'd0));
        chk("err_sticky", {67'd0, err_unexp_ok}, 68'd1);

        // three outstanding, then asynchronous reset mid-cycle
        for (int k = 0; k < 3; k++) cyc(mk(0, 1, 1, 0, 32'h0, 2'd2));
        inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        chk("async_rst_outputs", {62'd0, m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexp_ok}, 68'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("err_after_rst", {67'd0, err_unexp_ok}, 68'd0);
        // count must be zero: a response now is unexpected again
        cyc(mk(0, 0, 0, 1, 32'hDEAD_0001, 2'd0));
        chk("count_zero_after_rst", {67'd0, err_unexp_ok}, 68'd1);
        cyc(mk(1, 0, 1, 0, 32'h0, 2'd1));
        cyc(mk(0, 0, 0, 1, 32'hC0DE_0001, 2'd0));
        chk("sb_final", {36'd0, 32'(sb_q.size())}, 68'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
